// File: rtl/clock_divider_pkg.sv
// -----------------------------------------------------------------------------
// clock_divider_pkg
// Shared constants and helpers for the clock divider. The default
// frequencies are also reused by the traffic controller.
// -----------------------------------------------------------------------------
package clock_divider_pkg;

  localparam int CLK_HZ_DEFAULT = 50_000_000;
  localparam int OUT_HZ_DEFAULT = 1;

  // Counter width for a half period of 'half' clk cycles. A half period of
  // one cycle still needs a one-bit counter so the vector is never empty.
  function automatic int cnt_width(input int half);
    int w;
    w = $clog2(half);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/clock_divider_if.sv
// -----------------------------------------------------------------------------
// clock_divider_if
// Bundles the divider outputs for consumers that want them as one port.
//   clkout : divided clock, 50% duty
//   tick   : one-cycle strobe coincident with the clkout rising edge
// Modports: master drives the signals (divider side), slave observes them.
// -----------------------------------------------------------------------------
interface clock_divider_if;

  logic clkout;
  logic tick;

  modport master (output clkout, output tick);
  modport slave  (input  clkout, input  tick);

endinterface

// File: rtl/clock_divider.sv
// -----------------------------------------------------------------------------
// clock_divider
// Divides clk by 2*HALF, HALF = CLK_HZ / (2*OUT_HZ). A counter runs
// 0..HALF-1; on its terminal count the clkout flop toggles. tick is a
// registered strobe that rises together with clkout.
// Ports:
//   clk    in  : sole clock, rising edge
//   clkout out : divided clock, straight from a flop
//   rst    in  : synchronous active-high reset
//   tick   out : one-clk strobe on the cycle clkout goes 0->1
// -----------------------------------------------------------------------------
module clock_divider
  import clock_divider_pkg::*;
#(
  parameter int CLK_HZ = CLK_HZ_DEFAULT,
  parameter int OUT_HZ = OUT_HZ_DEFAULT
) (
  input  logic clk,
  output logic clkout,
  input  logic rst,
  output logic tick
);

  localparam int HALF  = CLK_HZ / (2 * OUT_HZ);
  localparam int CNT_W = cnt_width(HALF);

  // Output cannot be faster than half the input clock.
  generate
    if (HALF < 1) begin : g_bad_params
      $error("clock_divider: HALF=%0d < 1 (CLK_HZ=%0d OUT_HZ=%0d)", HALF, CLK_HZ, OUT_HZ);
    end
  endgenerate

  localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      clkout <= 1'b0;
      tick   <= 1'b0;
    end else if (cnt == LAST) begin
      cnt    <= '0;
      clkout <= ~clkout;
      // Toggling from low means this edge is the rising one.
      tick   <= ~clkout;
    end else begin
      cnt    <= cnt + CNT_W'(1);
      tick   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clock_divider.sv
// -----------------------------------------------------------------------------
// tb_clock_divider
// Directed bench for three divider instances sharing clk and rst:
//   HALF=4 (CLK_HZ=8), HALF=1 (CLK_HZ=2), and the defaults (HALF=25e6).
// After the n-th edge following reset release the expected values are:
//   clkout = (n / HALF) % 2, tick = (n % (2*HALF) == HALF), cnt = n % HALF.
// -----------------------------------------------------------------------------
module tb_clock_divider;

  logic clk;
  logic rst;

  int tests_run    = 0;
  int tests_failed = 0;

  clock_divider_if div4_if ();
  clock_divider_if div1_if ();
  clock_divider_if dflt_if ();

  clock_divider #(.CLK_HZ(8), .OUT_HZ(1)) dut4 (
    .clk    (clk),
    .clkout (div4_if.clkout),
    .rst    (rst),
    .tick   (div4_if.tick)
  );

  clock_divider #(.CLK_HZ(2), .OUT_HZ(1)) dut1 (
    .clk    (clk),
    .clkout (div1_if.clkout),
    .rst    (rst),
    .tick   (div1_if.tick)
  );

  clock_divider dutd (
    .clk    (clk),
    .clkout (dflt_if.clkout),
    .rst    (rst),
    .tick   (dflt_if.tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Check all instances after edges first..last since the last release.
  // The default instance is only checked for its first, never-wrapping count.
  task automatic run_edges(input int first, input int last, input bit chk_dflt);
    for (int n = first; n <= last; n++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("d4_clkout@%0d", n), 32'(div4_if.clkout), 32'((n / 4) % 2));
      check($sformatf("d4_tick@%0d", n),   32'(div4_if.tick),   32'(n % 8 == 4));
      check($sformatf("d4_cnt@%0d", n),    32'(dut4.cnt),       32'(n % 4));
      check($sformatf("d1_clkout@%0d", n), 32'(div1_if.clkout), 32'(n % 2));
      check($sformatf("d1_tick@%0d", n),   32'(div1_if.tick),   32'(n % 2 == 1));
      check($sformatf("d1_cnt@%0d", n),    32'(dut1.cnt),       32'd0);
      if (chk_dflt) begin
        check($sformatf("dd_cnt@%0d", n),    32'(dutd.cnt),       32'(n));
        check($sformatf("dd_clkout@%0d", n), 32'(dflt_if.clkout), 32'd0);
        check($sformatf("dd_tick@%0d", n),   32'(dflt_if.tick),   32'd0);
      end
    end
  endtask

  task automatic check_reset_state(input string when);
    check({when, "_d4_clkout"}, 32'(div4_if.clkout), 32'd0);
    check({when, "_d4_tick"},   32'(div4_if.tick),   32'd0);
    check({when, "_d4_cnt"},    32'(dut4.cnt),       32'd0);
    check({when, "_d1_clkout"}, 32'(div1_if.clkout), 32'd0);
    check({when, "_d1_tick"},   32'(div1_if.tick),   32'd0);
    check({when, "_dd_clkout"}, 32'(dflt_if.clkout), 32'd0);
    check({when, "_dd_cnt"},    32'(dutd.cnt),       32'd0);
  endtask

  initial begin
    rst = 1'b1;

    // Reset held for three edges.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_reset_state($sformatf("rst%0d", i));
    end
    rst = 1'b0;

    // Release, first rise at edge 4, then free run to edge 46
    // (clkout=1, cnt=2 on the HALF=4 instance).
    run_edges(1, 46, 1'b1);
    check("mid_d4_clkout_before", 32'(div4_if.clkout), 32'd1);
    check("mid_d4_cnt_before",    32'(dut4.cnt),       32'd2);

    // One-cycle reset mid-period.
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_state("mid");
    rst = 1'b0;

    // Timing restarts from the release edge.
    run_edges(1, 20, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/clock_divider.md
CLOCK_DIVIDER -- requirements
Module: clock_divider

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, input clock frequency in Hz.
REQ-002 Parameter OUT_HZ, default 1, output clock frequency in Hz.
REQ-003 Derived constant HALF = CLK_HZ / (2*OUT_HZ), integer division, and CNT_W = max(1, $clog2(HALF)).
REQ-004 Port list:
- clk  input  1  sole clock; one clock domain, all logic on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- clkout  output  1  divided clock; registered; 50% duty; period 2*HALF clk cycles.
- tick  output  1  one-clk-cycle strobe, high on the cycle clkout goes 0->1.
REQ-005 Parent connections SHALL be made by name; the port order is clk, clkout, rst, tick.

Function
REQ-006 Internal counter cnt, CNT_W bits, unsigned, SHALL count 0..HALF-1 on each clk rising edge while rst is low.
REQ-007 When cnt == HALF-1, cnt SHALL load 0 and clkout SHALL invert on that same edge; otherwise cnt increments by 1 and clkout holds.
REQ-008 cnt SHALL never exceed HALF-1; there is no wrap through 2^CNT_W.
REQ-009 tick SHALL be registered and SHALL be 1 exactly on the cycle after the edge where clkout changes 0->1; otherwise it is 0.
- tick and the rising clkout SHALL become visible on the same clk edge.
REQ-010 clkout high time and low time SHALL each equal exactly HALF clk cycles.
REQ-011 HALF == 1 SHALL be supported, in which case clkout toggles every clk cycle and tick pulses every 2nd cycle.
REQ-012 HALF < 1 (OUT_HZ > CLK_HZ/2) SHALL cause an elaboration-time error.
REQ-013 clkout SHALL come from a flop with no combinational gating, so it can drive downstream posedge logic.

Reset
REQ-014 When rst is high at a clk edge, the following SHALL take effect on that edge:
- cnt = 0
- clkout = 0
- tick = 0
REQ-015 Reset SHALL override counting, including when asserted mid-period; no partial period is preserved.
REQ-016 After rst deasserts, the first clkout rise and tick SHALL occur HALF clk edges later.
REQ-017 Subsequent rises SHALL follow every 2*HALF edges.
REQ-018 No initial blocks SHALL be relied upon for state; reset is the only initialization.

Structure
REQ-019 A shared package SHALL hold default constants CLK_HZ_DEFAULT = 50_000_000 and OUT_HZ_DEFAULT = 1, for reuse by the traffic controller.
REQ-020 No sub-modules SHALL be used; the block is a single counter plus a toggle flop plus a tick flop.
REQ-021 The design SHALL be synthesizable, with no vendor primitives and no derived-clock generation other than the clkout flop.

Verification (CLK_HZ=8, OUT_HZ=1, so HALF=4, unless noted)
REQ-022 Reset then release: rst high for 3 cycles, then low.
- clkout=0 and tick=0 during reset.
- clkout rises at the 4th edge after release.
- tick=1 for exactly that one cycle.
REQ-023 Free run for 40 cycles: clkout is high 4 and low 4 cycles repeatedly; tick pulses every 8 cycles; cnt stays in 0..3.
REQ-024 Reset mid-period: assert rst for 1 cycle while clkout=1 and cnt=2.
- Next cycle: clkout=0, cnt=0, tick=0.
- Next rise occurs 4 edges after release.
REQ-025 Minimum divide, CLK_HZ=2, OUT_HZ=1 (HALF=1): clkout toggles every edge; tick high on every 2nd cycle, coincident with clkout=1.
REQ-026 Default parameters: a check of HALF=25_000_000 and CNT_W=25 in elaboration; in simulation, the first clkout rise lands 25_000_000 edges after reset release.
REQ-027 Illegal parameters, CLK_HZ=1, OUT_HZ=1: elaboration fails with an error.
